// File: rtl/rom_load_pkg.sv
// Shared types and the ROM region map for the ROM download controller.
package rom_load_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned CNT_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RGN_CPU   = 2'd0,
    RGN_SOUND = 2'd1,
    RGN_GFX   = 2'd2,
    RGN_PROM  = 2'd3
  } region_t;

  // Regions are packed back to back in the image, in this order.
  localparam logic [ADDR_W-1:0] CPU_SIZE   = 25'h0006000;
  localparam logic [ADDR_W-1:0] SOUND_SIZE = 25'h0001000;
  localparam logic [ADDR_W-1:0] GFX_SIZE   = 25'h0000F00;
  localparam logic [ADDR_W-1:0] PROM_SIZE  = 25'h0000100;

  localparam logic [ADDR_W-1:0] CPU_BASE   = 25'h0000000;
  localparam logic [ADDR_W-1:0] SOUND_BASE = CPU_BASE + CPU_SIZE;
  localparam logic [ADDR_W-1:0] GFX_BASE   = SOUND_BASE + SOUND_SIZE;
  localparam logic [ADDR_W-1:0] PROM_BASE  = GFX_BASE + GFX_SIZE;
  localparam logic [ADDR_W-1:0] IMAGE_END  = PROM_BASE + PROM_SIZE;

endpackage

// File: rtl/rom_load_ctrl_if.sv
// HPS ioctl download stream in, per-region write stream out.
interface rom_load_ctrl_if;
  import rom_load_pkg::*;

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;

  logic [15:0]       dn_addr;
  logic [7:0]        dn_data;
  logic [1:0]        dn_rgn;
  logic              dn_wr;

  // HPS / bench side drives the ioctl stream and watches the region writes.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_rgn, dn_wr
  );

  // Controller side.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_rgn, dn_wr
  );
endinterface

// File: rtl/rom_region_decode.sv
// Maps a linear image address onto a region and an offset inside it.
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output region_t           rgn,
  output logic [15:0]       offset
);

  logic [ADDR_W-1:0] base;

  // Pick the highest region whose base is at or below the address.
  always_comb begin
    rgn  = RGN_CPU;
    base = CPU_BASE;
    if (addr >= PROM_BASE) begin
      rgn  = RGN_PROM;
      base = PROM_BASE;
    end else if (addr >= GFX_BASE) begin
      rgn  = RGN_GFX;
      base = GFX_BASE;
    end else if (addr >= SOUND_BASE) begin
      rgn  = RGN_SOUND;
      base = SOUND_BASE;
    end
    offset = 16'(addr - base);
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: routes the HPS image into regions and holds the
// game core in reset until a load has settled.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned TOTAL_BYTES = 32768
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  rom_load_ctrl_if.slave      bus,
  input  logic                soft_reset,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [7:0]          checksum
);

  localparam int unsigned       HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] TOTAL_ADDR = ADDR_W'(TOTAL_BYTES);
  localparam logic [CNT_W-1:0]  TOTAL_CNT  = CNT_W'(TOTAL_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_t            state_q, state_d;
  logic              dl_q;
  logic              dl_rise, dl_fall, wr_valid, in_range;
  logic              enter_load, in_load, accept, bad_wr;
  logic              hold_reload, hold_dec;
  logic [CNT_W-1:0]  byte_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  region_t           rgn;
  logic [15:0]       rgn_offset;

  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign dl_fall  = ~bus.ioctl_download & dl_q;
  assign wr_valid = bus.ioctl_download & bus.ioctl_wr;
  assign in_range = bus.ioctl_addr < TOTAL_ADDR;

  rom_region_decode u_decode (
    .addr   (bus.ioctl_addr),
    .rgn    (rgn),
    .offset (rgn_offset)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the strobes that steer the datapath; a write arriving with the download edge belongs to the new load.
  always_comb begin
    state_d     = state_q;
    enter_load  = 1'b0;
    hold_reload = 1'b0;
    hold_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (dl_fall) begin
          state_d     = ST_HOLD;
          hold_reload = 1'b1;
        end
      end
      ST_HOLD: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          enter_load = 1'b1;
        end else if (soft_reset) begin
          hold_reload = 1'b1;
        end else if (hold_cnt == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (dl_rise) begin
          state_d    = ST_LOAD;
          enter_load = 1'b1;
        end else if (soft_reset) begin
          state_d     = ST_HOLD;
          hold_reload = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_load = (state_q == ST_LOAD) | enter_load;
    accept  = in_load & wr_valid & in_range;
    bad_wr  = in_load & wr_valid & ~in_range;
  end

  // Edge detector, core reset and the hold countdown; the detector resets high so a download already active at release is not an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b1;
      core_reset <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      dl_q       <= bus.ioctl_download;
      core_reset <= (state_d != ST_RUN);
      if (hold_reload)   hold_cnt <= HOLD_INIT;
      else if (hold_dec) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Accepted bytes go out one cycle later; byte count, checksum and load status are tracked alongside.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.dn_wr   <= 1'b0;
      bus.dn_addr <= '0;
      bus.dn_data <= '0;
      bus.dn_rgn  <= '0;
      byte_cnt    <= '0;
      checksum    <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      bus.dn_wr <= accept;
      if (enter_load) begin
        byte_cnt <= '0;
        checksum <= '0;
        load_err <= 1'b0;
      end
      if (accept) begin
        bus.dn_addr <= rgn_offset;
        bus.dn_data <= bus.ioctl_dout;
        bus.dn_rgn  <= rgn;
        if (enter_load)            byte_cnt <= CNT_W'(1);
        else if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 1'b1;
        checksum <= (enter_load ? 8'd0 : checksum) + bus.ioctl_dout;
      end
      if (bad_wr) load_err <= 1'b1;
      if ((state_q == ST_LOAD) && dl_fall) begin
        if (byte_cnt == TOTAL_CNT) load_done <= 1'b1;
        else                       load_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a short hold time.
module tb_rom_load_ctrl;
  import rom_load_pkg::*;

  localparam int HOLD  = 16;
  localparam int TOTAL = 32768;

  logic       clk_sys    = 1'b0;
  logic       reset_n    = 1'b0;
  logic       soft_reset = 1'b0;
  logic       core_reset, load_done, load_err;
  logic [7:0] checksum;

  int checks    = 0;
  int errors    = 0;
  int wr_pulses = 0;

  rom_load_ctrl_if bus ();

  rom_load_ctrl #(.HOLD_CYCLES(HOLD), .TOTAL_BYTES(TOTAL)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .soft_reset (soft_reset),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .checksum   (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  // Every cycle with dn_wr high is one region write.
  always @(negedge clk_sys) if (bus.dn_wr === 1'b1) wr_pulses++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    #12;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset got %0b exp 1", core_reset); end
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_dn_wr got %0b exp 0", bus.dn_wr); end
    checks++; if (bus.dn_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_dn_addr got %0h exp 0", bus.dn_addr); end
    checks++; if (bus.dn_data !== 8'h0) begin errors++; $display("[TB] FAIL reset_dn_data got %0h exp 0", bus.dn_data); end
    checks++; if (bus.dn_rgn !== 2'd0) begin errors++; $display("[TB] FAIL reset_dn_rgn got %0d exp 0", bus.dn_rgn); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done got %0b exp 0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err got %0b exp 0", load_err); end
    checks++; if (checksum !== 8'h0) begin errors++; $display("[TB] FAIL reset_checksum got %0h exp 0", checksum); end
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL idle_core_reset got %0b exp 1", core_reset); end
  endtask

  task automatic test_short_download();
    int start;
    int n;
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    start = wr_pulses;
    for (int a = 0; a < 100; a++) begin
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = 8'(a);
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
    end
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    for (n = 0; n < 4 * HOLD; n++) begin
      @(posedge clk_sys); #1;
      if (core_reset === 1'b0) break;
    end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL short_reaches_run core_reset got %0b exp 0", core_reset); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL short_load_err got %0b exp 1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL short_load_done got %0b exp 0", load_done); end
    checks++; if (checksum !== 8'h56) begin errors++; $display("[TB] FAIL short_checksum got %0h exp 56", checksum); end
    checks++; if (wr_pulses - start !== 100) begin errors++; $display("[TB] FAIL short_pulses got %0d exp 100", wr_pulses - start); end
  endtask

  task automatic test_out_of_range();
    int n;
    logic [7:0] vals [4];
    vals = '{8'h10, 8'h20, 8'h30, 8'h40};
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int a = 0; a < 4; a++) begin
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = vals[a];
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
    end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_cleared got %0b exp 0", load_err); end
    bus.ioctl_addr = 25'h0008000;
    bus.ioctl_dout = 8'hAA;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("[TB] FAIL oor_dn_wr got %0b exp 0", bus.dn_wr); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_load_err got %0b exp 1", load_err); end
    checks++; if (checksum !== 8'hA0) begin errors++; $display("[TB] FAIL oor_checksum got %0h exp a0", checksum); end
    bus.ioctl_download = 1'b0;
    for (n = 0; n < 4 * HOLD; n++) begin
      @(posedge clk_sys); #1;
      if (core_reset === 1'b0) break;
    end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL oor_reaches_run core_reset got %0b exp 0", core_reset); end
  endtask

  task automatic test_reset_mid_load();
    int start;
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int a = 0; a < 500; a++) begin
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = 8'(a);
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
    end
    bus.ioctl_wr = 1'b0;
    checks++; if (bus.dn_addr !== 16'h01F3) begin errors++; $display("[TB] FAIL mid_dn_addr got %0h exp 1f3", bus.dn_addr); end
    checks++; if (checksum !== 8'h4E) begin errors++; $display("[TB] FAIL mid_checksum got %0h exp 4e", checksum); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_dn_wr got %0b exp 0", bus.dn_wr); end
    checks++; if (bus.dn_addr !== 16'h0) begin errors++; $display("[TB] FAIL mid_rst_dn_addr got %0h exp 0", bus.dn_addr); end
    checks++; if (bus.dn_data !== 8'h0) begin errors++; $display("[TB] FAIL mid_rst_dn_data got %0h exp 0", bus.dn_data); end
    checks++; if (checksum !== 8'h0) begin errors++; $display("[TB] FAIL mid_rst_checksum got %0h exp 0", checksum); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_core_reset got %0b exp 1", core_reset); end
    #3 reset_n = 1'b1;
    @(posedge clk_sys); #1;
    start = wr_pulses;
    for (int i = 0; i < 4; i++) begin
      bus.ioctl_addr = 25'd7;
      bus.ioctl_dout = 8'h77;
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      bus.ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
    end
    checks++; if (wr_pulses - start !== 0) begin errors++; $display("[TB] FAIL rearm_no_load pulses got %0d exp 0", wr_pulses - start); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL rearm_core_reset got %0b exp 1", core_reset); end
    bus.ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_full_download();
    int start;
    int hi;
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    start = wr_pulses;
    for (int a = 0; a < TOTAL; a++) begin
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = 8'(a);
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      if (a == 32'h5FFF) begin
        checks++; if (bus.dn_rgn !== 2'd0 || bus.dn_addr !== 16'h5FFF) begin errors++; $display("[TB] FAIL full_5fff got rgn %0d addr %0h exp rgn 0 addr 5fff", bus.dn_rgn, bus.dn_addr); end
      end
      if (a == 32'h6000) begin
        checks++; if (bus.dn_rgn !== 2'd1 || bus.dn_addr !== 16'h0) begin errors++; $display("[TB] FAIL full_6000 got rgn %0d addr %0h exp rgn 1 addr 0", bus.dn_rgn, bus.dn_addr); end
      end
      if (a == 32'h7000) begin
        checks++; if (bus.dn_rgn !== 2'd2 || bus.dn_addr !== 16'h0) begin errors++; $display("[TB] FAIL full_7000 got rgn %0d addr %0h exp rgn 2 addr 0", bus.dn_rgn, bus.dn_addr); end
      end
      if (a == 32'h7F05) begin
        checks++; if (bus.dn_rgn !== 2'd3 || bus.dn_addr !== 16'h5 || bus.dn_data !== 8'h05) begin errors++; $display("[TB] FAIL full_7f05 got rgn %0d addr %0h data %0h exp rgn 3 addr 5 data 5", bus.dn_rgn, bus.dn_addr, bus.dn_data); end
      end
    end
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    hi = 0;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(posedge clk_sys); #1;
      if (core_reset === 1'b1) hi++;
      else break;
    end
    checks++; if (hi !== HOLD) begin errors++; $display("[TB] FAIL full_hold_len got %0d exp %0d", hi, HOLD); end
    checks++; if (wr_pulses - start !== TOTAL) begin errors++; $display("[TB] FAIL full_pulses got %0d exp %0d", wr_pulses - start, TOTAL); end
    checks++; if (checksum !== 8'h00) begin errors++; $display("[TB] FAIL full_checksum got %0h exp 0", checksum); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL full_load_done got %0b exp 1", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL full_load_err got %0b exp 0", load_err); end
  endtask

  task automatic test_soft_reset();
    int hi;
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL soft_pre_run core_reset got %0b exp 0", core_reset); end
    @(posedge clk_sys); #1;
    soft_reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 4 * HOLD; i++) begin
      @(posedge clk_sys); #1;
      if (i == 2) soft_reset = 1'b0;
      if (core_reset === 1'b1) hi++;
      else break;
    end
    soft_reset = 1'b0;
    checks++; if (hi !== HOLD + 2) begin errors++; $display("[TB] FAIL soft_hold_len got %0d exp %0d", hi, HOLD + 2); end
    checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL soft_load_done got %0b exp 1", load_done); end
  endtask

  task automatic test_wr_without_download();
    int start;
    start = wr_pulses;
    for (int i = 0; i < 6; i++) begin
      bus.ioctl_addr = 25'(i + 16);
      bus.ioctl_dout = 8'hFF;
      bus.ioctl_wr   = 1'b1;
      @(posedge clk_sys); #1;
      bus.ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
    end
    checks++; if (wr_pulses - start !== 0) begin errors++; $display("[TB] FAIL idle_wr_pulses got %0d exp 0", wr_pulses - start); end
    checks++; if (checksum !== 8'h00) begin errors++; $display("[TB] FAIL idle_wr_checksum got %0h exp 0", checksum); end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL idle_wr_core_reset got %0b exp 0", core_reset); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    bus.ioctl_addr     = 25'h0007000;
    bus.ioctl_dout     = 8'h5A;
    bus.ioctl_wr       = 1'b1;
    @(posedge clk_sys); #1;
    checks++; if (bus.dn_wr !== 1'b1 || bus.dn_rgn !== 2'd2 || bus.dn_addr !== 16'h0 || bus.dn_data !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_first got wr %0b rgn %0d addr %0h data %0h exp 1 2 0 5a", bus.dn_wr, bus.dn_rgn, bus.dn_addr, bus.dn_data); end
    checks++; if (checksum !== 8'h5A) begin errors++; $display("[TB] FAIL b2b_checksum1 got %0h exp 5a", checksum); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL b2b_core_reset got %0b exp 1", core_reset); end
    bus.ioctl_addr = 25'h0007F05;
    bus.ioctl_dout = 8'h01;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
    checks++; if (bus.dn_wr !== 1'b1 || bus.dn_rgn !== 2'd3 || bus.dn_addr !== 16'h5) begin errors++; $display("[TB] FAIL b2b_second got wr %0b rgn %0d addr %0h exp 1 3 5", bus.dn_wr, bus.dn_rgn, bus.dn_addr); end
    checks++; if (checksum !== 8'h5B) begin errors++; $display("[TB] FAIL b2b_checksum2 got %0h exp 5b", checksum); end
    @(posedge clk_sys); #1;
    checks++; if (bus.dn_wr !== 1'b0 || bus.dn_addr !== 16'h5 || bus.dn_data !== 8'h01) begin errors++; $display("[TB] FAIL b2b_hold got wr %0b addr %0h data %0h exp 0 5 1", bus.dn_wr, bus.dn_addr, bus.dn_data); end
    bus.ioctl_download = 1'b0;
    for (n = 0; n < 4 * HOLD; n++) begin
      @(posedge clk_sys); #1;
      if (core_reset === 1'b0) break;
    end
    checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL b2b_reaches_run core_reset got %0b exp 0", core_reset); end
    checks++; if (load_done !== 1'b1 || load_err !== 1'b1) begin errors++; $display("[TB] FAIL b2b_status got done %0b err %0b exp done 1 err 1", load_done, load_err); end
  endtask

  initial begin
    $display("[TB] rom_load_ctrl bench start");
    test_reset();
    test_short_download();
    test_out_of_range();
    test_reset_mid_load();
    test_full_download();
    test_soft_reset();
    test_wr_without_download();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024, sets core-reset hold length after a load or reset request.
REQ-002 Parameter TOTAL_BYTES, default 32768, sets the expected download length; the default equals the sum of the region sizes.
REQ-003 clk_sys  in  1  system clock; every output is registered on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high while the HPS is streaming a ROM image.
REQ-006 ioctl_wr  in  1  one-cycle strobe; ioctl_addr and ioctl_dout are valid while it is high.
REQ-007 ioctl_addr  in  25  linear byte address within the image.
REQ-008 ioctl_dout  in  8  image byte.
REQ-009 soft_reset  in  1  level-sensitive request for a core restart from the OSD or a button.
REQ-010 dn_addr  out  16  byte offset within the selected region.
REQ-011 dn_data  out  8  byte to write.
REQ-012 dn_rgn  out  2  region select: 0 cpu, 1 sound, 2 gfx, 3 prom.
REQ-013 dn_wr  out  1  one-cycle write strobe.
REQ-014 core_reset  out  1  active-high reset to the game core.
REQ-015 load_done  out  1  high once at least one load has completed.
REQ-016 load_err  out  1  sticky load-error flag.
REQ-017 checksum  out  8  modulo-256 sum of the accepted bytes.

Function
REQ-018 The controller has four states: IDLE, LOAD, HOLD and RUN; it enters IDLE on reset.
REQ-019 IDLE: core_reset=1; a rising edge on ioctl_download moves to LOAD.
REQ-020 LOAD entry:
- clears the byte counter and checksum;
- clears load_err;
- keeps core_reset=1.
REQ-021 In LOAD, an ioctl_wr with ioctl_addr < TOTAL_BYTES is accepted.
- Region is decoded against the package table; dn_rgn and dn_addr (= ioctl_addr − region base) are registered.
- dn_wr pulses exactly one cycle after ioctl_wr.
- The counter increments and the byte is added to checksum.
REQ-022 An ioctl_wr with ioctl_addr ≥ TOTAL_BYTES produces no dn_wr and sets load_err.
REQ-023 An ioctl_wr while ioctl_download is low is ignored in every state.
REQ-024 A falling edge of ioctl_download in LOAD:
- moves to HOLD;
- sets load_err if the counter ≠ TOTAL_BYTES;
- sets load_done when the counter = TOTAL_BYTES.
REQ-025 HOLD: core_reset=1; a down-counter is loaded with HOLD_CYCLES−1 on entry; the state moves to RUN in the cycle after the counter reaches 0.
REQ-026 RUN: core_reset=0; soft_reset=1 moves to HOLD, and HOLD restarts its count while soft_reset stays high.
REQ-027 A rising edge of ioctl_download in HOLD or RUN moves to LOAD; the previous checksum is discarded and load_done is kept.
REQ-028 If ioctl_download rises and ioctl_wr is high in the same cycle, the state enters LOAD and the byte is accepted.
REQ-029 Counter widths:
- byte counter: 17 bits, saturating;
- hold counter: $clog2(HOLD_CYCLES) bits;
- checksum: wraps modulo 256.
REQ-030 dn_data and dn_addr hold their last values when dn_wr=0.

Reset
REQ-031 With reset_n=0, outputs are forced asynchronously:
- state=IDLE, core_reset=1;
- dn_wr=0, dn_addr=0, dn_data=0, dn_rgn=0;
- load_done=0, load_err=0, checksum=0, all counters=0.
REQ-032 A reset_n assertion mid-LOAD aborts the load; after release the controller waits in IDLE for a new download edge.
REQ-033 The ioctl_download edge detector is re-armed by reset_n, so a download still high at release is not treated as a rising edge.

Structure
REQ-034 A shared package rom_load_pkg holds:
- the state enum;
- the region enum;
- per-region base/size constants: cpu 0x0000/24K, sound 0x6000/4K, gfx 0x7000/3.75K, prom 0x7F00/256.
REQ-035 One sub-module, rom_region_decode, performs the combinational address-to-region and offset mapping from the package table.

Verification
REQ-036 Full 32768-byte ramp download (byte = addr[7:0]):
- 32768 dn_wr pulses;
- address 0x6000 gives dn_rgn=1, dn_addr=0;
- address 0x7F05 gives dn_rgn=3, dn_addr=5;
- checksum=0x00, load_done=1, load_err=0;
- core_reset falls exactly HOLD_CYCLES cycles after the download falls.
REQ-037 Short download of 100 bytes, then download falls: load_err=1, load_done=0, the state still reaches RUN.
REQ-038 Write at address 0x8000 during LOAD: no dn_wr, load_err=1.
REQ-039 soft_reset pulsed for 3 cycles in RUN: core_reset=1 for HOLD_CYCLES+2 cycles, then 0.
REQ-040 reset_n asserted at byte 500 of a load:
- outputs reach their reset values immediately;
- a new download from 0 completes cleanly.
REQ-041 ioctl_wr toggled while ioctl_download=0 in RUN: no dn_wr, and the checksum is unchanged.
